// File: rtl/ifid_queue_if.sv
// ifid_queue_if: valid/ready entry channel carrying PC, instruction and fault flag
interface ifid_queue_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [PC_WIDTH-1:0]   pc;
  logic [INST_WIDTH-1:0] inst;
  logic                  fault;
  modport master (output valid, pc, inst, fault, input ready);
  modport slave  (input valid, pc, inst, fault, output ready);
endinterface

// File: rtl/ifid_queue.sv
// ifid_queue: DEPTH-entry in-order IF/ID buffer with flush and NOP-on-empty
module ifid_queue #(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013,
  localparam int                   CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ifid_queue_if.slave          fetch,
  ifid_queue_if.master         decode,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [PC_WIDTH-1:0]   mem_pc   [DEPTH];
  logic [INST_WIDTH-1:0] mem_inst [DEPTH];
  logic                  mem_fault[DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr, ptr_diff;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  push, pop;

  // handshake qualifiers; ready/valid depend only on registered occupancy
  always_comb begin
    fetch.ready  = cnt != CNT_WIDTH'(DEPTH);
    decode.valid = cnt != '0;
    push         = fetch.valid & fetch.ready;
    pop          = decode.valid & decode.ready;
    ptr_diff     = wr_ptr - rd_ptr;
    count        = cnt;
  end

  // pointers and occupancy; flush overrides any push/pop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push != pop) cnt <= push ? cnt + CNT_WIDTH'(1) : cnt - CNT_WIDTH'(1);
    end
  end

  // entry storage is left unreset; stale contents are hidden by the output mask
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_pc[wr_ptr]    <= fetch.pc;
      mem_inst[wr_ptr]  <= fetch.inst;
      mem_fault[wr_ptr] <= fetch.fault;
    end
  end

  // head entry to decode, or a NOP bubble when empty
  always_comb begin
    decode.pc    = decode.valid ? mem_pc[rd_ptr]    : '0;
    decode.inst  = decode.valid ? mem_inst[rd_ptr]  : NOP_INST;
    decode.fault = decode.valid ? mem_fault[rd_ptr] : 1'b0;
  end

  // occupancy stays in range and agrees with the pointer distance
  always @(posedge clk) begin
    if (rst_n) begin
      assert (32'(cnt) <= DEPTH);
      assert (ptr_diff == AW'(cnt));
    end
  end
endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: directed self-checking bench for ifid_queue (DEPTH=2 and DEPTH=4)
module tb_ifid_queue;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] count_a;
  logic [2:0] count_b;
  int         checks = 0;
  int         errors = 0;

  ifid_queue_if fa();
  ifid_queue_if da();
  ifid_queue_if fb();
  ifid_queue_if db();

  ifid_queue #(.DEPTH(2)) dut_a (.clk(clk), .rst_n(rst_n), .fetch(fa), .decode(da), .flush(flush), .count(count_a));
  ifid_queue #(.DEPTH(4)) dut_b (.clk(clk), .rst_n(rst_n), .fetch(fb), .decode(db), .flush(1'b0), .count(count_b));

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5a00_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [31:0] pc, input logic f, input logic r);
    fa.valid = v;
    fa.pc    = pc;
    fa.inst  = inst_of(pc);
    fa.fault = f;
    da.ready = r;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] npc;
    logic [15:0] vpat;
    logic [15:0] rpat;
    int          pushed;
    int          popped;
    rst_n = 1'b0;
    flush = 1'b0;
    set_a(0, 0, 0, 0);
    fb.valid = 0; fb.pc = 0; fb.inst = 0; fb.fault = 0; db.ready = 0;
    #12;
    chk("rst_in_ready", fa.ready, 1);
    chk("rst_out_valid", da.valid, 0);
    chk("rst_out_inst", da.inst, 32'h13);
    chk("rst_out_pc", da.pc, 0);
    chk("rst_out_fault", da.fault, 0);
    chk("rst_count", count_a, 0);
    rst_n = 1'b1;
    set_a(0, 0, 0, 1);
    step;
    step;
    chk("idle_count", count_a, 0);
    chk("idle_out_valid", da.valid, 0);
    chk("idle_out_inst", da.inst, 32'h13);
    set_a(1, 32'h0, 0, 1);
    step;
    chk("tp_pc0", da.pc, 32'h0);
    chk("tp_inst0", da.inst, inst_of(32'h0));
    chk("tp_count0", count_a, 1);
    set_a(1, 32'h4, 0, 1);
    step;
    chk("tp_pc4", da.pc, 32'h4);
    chk("tp_count4", count_a, 1);
    set_a(1, 32'h8, 0, 1);
    step;
    chk("tp_pc8", da.pc, 32'h8);
    chk("tp_count8", count_a, 1);
    set_a(0, 32'h0, 0, 1);
    step;
    chk("tp_drain_count", count_a, 0);
    chk("tp_drain_inst", da.inst, 32'h13);
    set_a(1, 32'h0, 0, 0);
    step;
    chk("st_count1", count_a, 1);
    chk("st_in_ready1", fa.ready, 1);
    set_a(1, 32'h4, 0, 0);
    step;
    chk("st_count2", count_a, 2);
    chk("st_in_ready_full", fa.ready, 0);
    chk("st_head_hold", da.pc, 32'h0);
    set_a(1, 32'h8, 0, 0);
    step;
    chk("st_count_held", count_a, 2);
    chk("st_head_still", da.pc, 32'h0);
    set_a(1, 32'h8, 0, 1);
    step;
    chk("st_pop_pc4", da.pc, 32'h4);
    chk("st_pop_count", count_a, 1);
    step;
    chk("st_pc8", da.pc, 32'h8);
    chk("st_pc8_inst", da.inst, inst_of(32'h8));
    chk("st_pc8_count", count_a, 1);
    set_a(0, 32'h0, 0, 1);
    step;
    chk("st_empty", da.valid, 0);
    set_a(1, 32'h10, 0, 0);
    step;
    set_a(1, 32'h14, 0, 0);
    step;
    chk("fl_full", count_a, 2);
    set_a(1, 32'h20, 0, 1);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("fl_count", count_a, 0);
    chk("fl_out_valid", da.valid, 0);
    chk("fl_out_inst", da.inst, 32'h13);
    chk("fl_in_ready", fa.ready, 1);
    set_a(0, 32'h0, 0, 1);
    step;
    chk("fl_no_0x20", da.valid, 0);
    set_a(1, 32'h30, 0, 0);
    step;
    chk("fl2_count1", count_a, 1);
    set_a(1, 32'h34, 0, 1);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("fl2_push_dropped", count_a, 0);
    set_a(0, 32'h0, 0, 0);
    step;
    chk("fl2_still_empty", da.valid, 0);
    set_a(1, 32'h100, 1, 0);
    step;
    chk("ft_fault", da.fault, 1);
    chk("ft_pc", da.pc, 32'h100);
    set_a(1, 32'h104, 0, 0);
    step;
    chk("ft_count2", count_a, 2);
    chk("ft_fault_hold", da.fault, 1);
    set_a(0, 32'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", count_a, 0);
    chk("ar_out_valid", da.valid, 0);
    chk("ar_out_inst", da.inst, 32'h13);
    chk("ar_out_pc", da.pc, 0);
    chk("ar_out_fault", da.fault, 0);
    chk("ar_in_ready", fa.ready, 1);
    #1 rst_n = 1'b1;
    step;
    chk("ar_after_edge", count_a, 0);
    vpat   = 16'b1110_1101_1011_1111;
    rpat   = 16'b1101_0110_1100_0000;
    npc    = 32'h200;
    pushed = 0;
    popped = 0;
    for (int i = 0; i < 80 && (pushed < 10 || q.size() != 0); i++) begin
      logic vb, rb, push, pop;
      vb = pushed < 10 && vpat[i % 16];
      rb = pushed >= 10 || rpat[i % 16];
      fb.valid = vb;
      fb.pc    = npc;
      fb.inst  = inst_of(npc);
      db.ready = rb;
      #1;
      chk("w_in_ready", fb.ready, q.size() != 4);
      push = vb && q.size() != 4;
      pop  = rb && q.size() != 0;
      step;
      if (pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (push) begin
        q.push_back(npc);
        npc += 4;
        pushed++;
      end
      chk("w_count", count_b, q.size());
      if (q.size() != 0) begin
        chk("w_head_pc", db.pc, q[0]);
        chk("w_head_inst", db.inst, inst_of(q[0]));
      end else begin
        chk("w_empty", db.valid, 0);
      end
    end
    fb.valid = 0;
    chk("w_popped", popped, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
